// File: rtl/irq_conditioner_pkg.sv
// Shared types and defaults for the external interrupt conditioner.
package irq_pkg;

  // Request state machine encoding.
  typedef enum logic [1:0] {
    ISIdle,
    ISActive,
    ISHoldoff
  } IrqState;

  // Default parameter values used by the conditioner and its sub-blocks.
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_PULSE_CYCLES    = 64;
  localparam int DEF_HOLDOFF_CYCLES  = 8;
  localparam int DEF_CNT_WIDTH       = 8;

  // Width of a counter that must hold values 0..max_val; never narrower than 1 bit.
  function automatic int cnt_w(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/irq_conditioner_if.sv
// Pin-side / CPU-side signal bundle of the interrupt conditioner.
interface irq_conditioner_if import irq_pkg::*; #(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
  logic                 irq_n_i;
  logic                 ack_i;
  logic                 irq_n_o;
  logic                 pending_o;
  logic [CNT_WIDTH-1:0] missed_cnt_o;

  // Board pin and CPU acknowledge driver.
  modport master (
    output irq_n_i,
    output ack_i,
    input  irq_n_o,
    input  pending_o,
    input  missed_cnt_o
  );

  // The conditioner itself.
  modport slave (
    input  irq_n_i,
    input  ack_i,
    output irq_n_o,
    output pending_o,
    output missed_cnt_o
  );
endinterface

// File: rtl/irq_conditioner_sync_debounce.sv
// Synchronizer, debounce filter and registered falling-edge detector for the
// asynchronous interrupt pin.
module sync_debounce import irq_pkg::*; #(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic fall_o
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_lvl;
  logic [DW-1:0]          deb_cnt_q, deb_cnt_d, deb_inc;
  logic                   level_q, level_d;
  logic                   level_dly_q, level_dly_d;
  logic                   fall_q, fall_d;

  // Shift the pin through the synchronizer chain; the last stage is the usable level.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], async_i};
    sync_lvl = sync_q[SYNC_STAGES-1];
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_inc   = deb_cnt_q + DW'(1);
    level_d   = level_q;
    deb_cnt_d = '0;
    if (sync_lvl != level_q) begin
      if (deb_inc == DW'(DEBOUNCE_CYCLES)) begin
        level_d = sync_lvl;
      end else begin
        deb_cnt_d = deb_inc;
      end
    end
  end

  // Fall pulse is taken from the registered level, so it appears one cycle after the level drops.
  always_comb begin
    level_dly_d = level_q;
    fall_d      = level_dly_q & ~level_q;
  end

  // Filter state; everything idles high so a pin held low through reset still yields one event.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q      <= '1;
      deb_cnt_q   <= '0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      deb_cnt_q   <= deb_cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      fall_q      <= fall_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/irq_conditioner.sv
// Turns debounced falling edges of the external interrupt pin into well-formed,
// active-low CPU interrupt requests with a one-deep queue and a missed-event count.
module irq_conditioner import irq_pkg::*; #(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic           clk_i,
  input  logic           reset_i,
  irq_conditioner_if.slave bus
);

  localparam int PW = cnt_w(PULSE_CYCLES);
  localparam int HW = cnt_w(HOLDOFF_CYCLES);

  logic                 fall;
  logic                 deb_level;

  IrqState              state_q, state_d;
  logic                 irq_n_q, irq_n_d;
  logic                 pending_q, pending_d;
  logic [CNT_WIDTH-1:0] missed_q, missed_d;
  logic [PW-1:0]        pulse_cnt_q, pulse_cnt_d, pulse_inc;
  logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
  logic                 pulse_expired;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (bus.irq_n_i),
    .level_o (deb_level),
    .fall_o  (fall)
  );

  // An event pulse always follows a cycle in which the debounced level was already low.
  a_fall_after_low: assert property (@(posedge clk_i) disable iff (reset_i)
    fall |-> !$past(deb_level));

  // Next-state logic for the request FSM, the one-deep queue and the missed counter.
  always_comb begin
    state_d       = state_q;
    irq_n_d       = irq_n_q;
    pending_d     = pending_q;
    missed_d      = missed_q;
    pulse_cnt_d   = pulse_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    pulse_inc     = pulse_cnt_q + PW'(1);
    pulse_expired = (PULSE_CYCLES != 0) && (pulse_inc == PW'(PULSE_CYCLES));

    case (state_q)
      ISIdle: begin
        irq_n_d = 1'b1;
        if (fall || pending_q) begin
          state_d     = ISActive;
          irq_n_d     = 1'b0;
          pulse_cnt_d = '0;
          // A queued entry is consumed; a simultaneous new event takes its place.
          pending_d   = fall & pending_q;
        end
      end

      ISActive: begin
        pulse_cnt_d = pulse_inc;
        if (bus.ack_i || pulse_expired) begin
          state_d    = ISHoldoff;
          irq_n_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end

      ISHoldoff: begin
        if (hold_cnt_q == HW'(HOLDOFF_CYCLES - 1)) begin
          state_d = ISIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      default: begin
        state_d = ISIdle;
        irq_n_d = 1'b1;
      end
    endcase

    // Events while a request is in service are queued once, then counted as missed.
    if (state_q != ISIdle && fall) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (!(&missed_q)) begin
        missed_d = missed_q + CNT_WIDTH'(1);
      end
    end
  end

  // Register FSM state and all outputs so nothing reaches the CPU combinationally.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ISIdle;
      irq_n_q     <= 1'b1;
      pending_q   <= 1'b0;
      missed_q    <= '0;
      pulse_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      irq_n_q     <= irq_n_d;
      pending_q   <= pending_d;
      missed_q    <= missed_d;
      pulse_cnt_q <= pulse_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.irq_n_o      = irq_n_q;
  assign bus.pending_o    = pending_q;
  assign bus.missed_cnt_o = missed_q;

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed bench for irq_conditioner: dut_a uses default timing, dut_b waits
// for ack indefinitely (PULSE_CYCLES = 0).
module tb_irq_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  irq_conditioner_if #(.CNT_WIDTH(8)) bus_a ();
  irq_conditioner_if #(.CNT_WIDTH(8)) bus_b ();

  irq_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .PULSE_CYCLES(64),
    .HOLDOFF_CYCLES(8), .CNT_WIDTH(8)
  ) dut_a (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus_a.slave)
  );

  irq_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .PULSE_CYCLES(0),
    .HOLDOFF_CYCLES(8), .CNT_WIDTH(8)
  ) dut_b (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus_b.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n, m, bad;
  logic lvl_min;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Count edges until the selected irq_n_o goes low (bounded).
  task automatic wait_low(input bit sel, output int cnt);
    cnt = 0;
    while ((sel ? bus_b.irq_n_o : bus_a.irq_n_o) && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  // One clean pin event on dut_b: 20 cycles low, 20 cycles high.
  task automatic pulse_b();
    bus_b.irq_n_i = 1'b0;
    ticks(20);
    bus_b.irq_n_i = 1'b1;
    ticks(20);
  endtask

  initial begin
    bus_a.irq_n_i = 1'b1; bus_a.ack_i = 1'b0;
    bus_b.irq_n_i = 1'b1; bus_b.ack_i = 1'b0;

    // Reset values are visible before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_irq_a", bus_a.irq_n_o, 1);
    chk("rst_pend_a", bus_a.pending_o, 0);
    chk("rst_miss_a", bus_a.missed_cnt_o, 0);
    chk("rst_irq_b", bus_b.irq_n_o, 1);
    ticks(3);
    rst = 1'b0;

    // Quiet pin for 100 cycles
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus_a.irq_n_o !== 1'b1 || bus_a.pending_o !== 1'b0 || bus_a.missed_cnt_o !== 8'd0) bad++;
      if (bus_b.irq_n_o !== 1'b1 || bus_b.pending_o !== 1'b0 || bus_b.missed_cnt_o !== 8'd0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Held-low pin, acked 5 cycles into the request
    bus_a.irq_n_i = 1'b0;
    wait_low(1'b0, n);
    chk("ack_latency", n, 20);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_a.irq_n_o !== 1'b0) bad++;
    end
    chk("ack_held_low", bad, 0);
    bus_a.ack_i = 1'b1;
    tick();
    bus_a.ack_i = 1'b0;
    chk("ack_release", bus_a.irq_n_o, 1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus_a.irq_n_o !== 1'b1) bad++;
    end
    chk("ack_no_second", bad, 0);
    chk("ack_pend", bus_a.pending_o, 0);
    bus_a.irq_n_i = 1'b1;
    ticks(40);

    // 10-cycle glitch is rejected
    bus_a.irq_n_i = 1'b0;
    bad = 0;
    lvl_min = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) bus_a.irq_n_i = 1'b1;
      tick();
      if (bus_a.irq_n_o !== 1'b1) bad++;
      lvl_min = lvl_min & dut_a.u_sd.level_o;
    end
    chk("glitch_irq", bad, 0);
    chk("glitch_level", lvl_min, 1);

    // No ack: request times out after 64 cycles
    bus_a.irq_n_i = 1'b0;
    wait_low(1'b0, n);
    chk("tmo_latency", n, 20);
    m = 0;
    while (bus_a.irq_n_o === 1'b0 && m < 200) begin
      m++;
      tick();
    end
    chk("tmo_width", m, 64);
    bus_a.irq_n_i = 1'b1;
    ticks(40);

    // dut_b: three falls in one request -> one queued, one missed
    for (int i = 0; i < 3; i++) pulse_b();
    chk("q3_irq", bus_b.irq_n_o, 0);
    chk("q3_pend", bus_b.pending_o, 1);
    chk("q3_miss", bus_b.missed_cnt_o, 1);
    bus_b.ack_i = 1'b1;
    tick();
    bus_b.ack_i = 1'b0;
    n = 0;
    while (bus_b.irq_n_o === 1'b1 && n < 30) begin
      n++;
      tick();
    end
    chk("q3_gap", n, 9);
    chk("q3_pend_used", bus_b.pending_o, 0);
    bus_b.ack_i = 1'b1;
    tick();
    bus_b.ack_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_b.irq_n_o !== 1'b1) bad++;
    end
    chk("q3_drained", bad, 0);

    // dut_b: 300 events, no acks -> counter saturates
    for (int i = 0; i < 300; i++) pulse_b();
    chk("sat_miss", bus_b.missed_cnt_o, 255);
    chk("sat_pend", bus_b.pending_o, 1);
    chk("sat_irq", bus_b.irq_n_o, 0);

    // Asynchronous reset mid-request with the pin held low
    bus_b.irq_n_i = 1'b0;
    ticks(5);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_irq", bus_b.irq_n_o, 1);
    chk("mid_rst_pend", bus_b.pending_o, 0);
    chk("mid_rst_miss", bus_b.missed_cnt_o, 0);
    ticks(2);
    rst = 1'b0;
    wait_low(1'b1, n);
    chk("held_thru_rst", n, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
